rgb_pwm: RTL

RGB_PWM -- requirements
Module: rgb_pwm

---
 rtl/rgb_pwm.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rgb_pwm.sv
// rgb_pwm: three-channel 8-bit LED PWM with double-buffered duties and a small CPU register port.
// Build option: define RGB_PWM_FADE_EN to add the triangle breathing envelope (control bit2).
module rgb_pwm #(
    parameter int PRESCALE = 47
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b
);

    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0] PS_TC = PW'(PRESCALE);

    logic [7:0]    pend_r, pend_g, pend_b;
    logic [7:0]    act_r, act_g, act_b;
    logic [7:0]    eff_r, eff_g, eff_b;
    logic          en, en_nxt, fade_q;
    logic [PW-1:0] presc;
    logic [7:0]    period;
    logic [7:0]    rd_data;
    logic          tick, wrap, wr_en, rd_en;

    assign wr_en  = cs & we;
    assign rd_en  = cs & ~we;
    assign tick   = en & (presc == PS_TC);
    assign wrap   = tick & (period == 8'hFF);
    // Outputs follow the enable as written, so a disable blanks the LEDs on the write edge itself.
    assign en_nxt = (wr_en && addr == 2'd3) ? din[0] : en;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r <= '0;
            pend_g <= '0;
            pend_b <= '0;
            en     <= 1'b0;
        end else if (wr_en) begin
            case (addr)
                2'd0:    pend_r <= din;
                2'd1:    pend_g <= din;
                2'd2:    pend_b <= din;
                default: en     <= din[0];
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0:    rd_data = pend_r;
            2'd1:    rd_data = pend_g;
            2'd2:    rd_data = pend_b;
            default: rd_data = {5'b0, fade_q, 1'b0, en};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            dout <= '0;
        else if (rd_en)
            dout <= rd_data;
    end

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            presc  <= '0;
            period <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick)
                period <= period + 8'd1;
        end
    end

    // Active duties only move at a period boundary (or while idle) so a period is never cut short.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_r <= '0;
            act_g <= '0;
            act_b <= '0;
        end else if (!en || wrap) begin
            act_r <= pend_r;
            act_g <= pend_g;
            act_b <= pend_b;
        end
    end

`ifdef RGB_PWM_FADE_EN
    logic [7:0] env;
    logic       env_down;

    function automatic logic [7:0] scale(input logic [7:0] d, input logic [7:0] e);
        return 8'(({8'b0, d} * {8'b0, e}) >> 8);
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            fade_q <= 1'b0;
        else if (wr_en && addr == 2'd3)
            fade_q <= din[2];
    end

    // Envelope parks at the bottom while fading is off so each fade starts from dark.
    always_ff @(posedge clk) begin
        if (reset || !fade_q) begin
            env      <= '0;
            env_down <= 1'b0;
        end else if (wrap) begin
            if (!env_down) begin
                if (env == 8'hFF) begin
                    env      <= 8'hFE;
                    env_down <= 1'b1;
                end else begin
                    env <= env + 8'd1;
                end
            end else begin
                if (env == 8'h00) begin
                    env      <= 8'h01;
                    env_down <= 1'b0;
                end else begin
                    env <= env - 8'd1;
                end
            end
        end
    end

    assign eff_r = fade_q ? scale(act_r, env) : act_r;
    assign eff_g = fade_q ? scale(act_g, env) : act_g;
    assign eff_b = fade_q ? scale(act_b, env) : act_b;
`else
    assign fade_q = 1'b0;
    assign eff_r  = act_r;
    assign eff_g  = act_g;
    assign eff_b  = act_b;
`endif

    always_ff @(posedge clk) begin
        if (reset || !en_nxt) begin
            pwm_r <= 1'b0;
            pwm_g <= 1'b0;
            pwm_b <= 1'b0;
        end else begin
            pwm_r <= (period < eff_r);
            pwm_g <= (period < eff_g);
            pwm_b <= (period < eff_b);
        end
    end

endmodule
